// File: rtl/serial_vec_stream.sv
// Parallel-to-serial lane streamer: CORE-lane vector in, one lane per beat out, 1 clk accept-to-first-beat.
// Backpressure: out_ready=0 holds the active vector; one more vector parks in pending, then in_ready drops.
module serial_vec_stream #(
  parameter int DWIDTH = 16,
  parameter int CORE   = 16,
  parameter int CWIDTH = $clog2(CORE + 1)
) (
  input  logic                                clk,
  input  logic                                xrst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [CORE-1:0][DWIDTH-1:0]  in_data,
  input  logic        [CWIDTH-1:0]            in_len,
  input  logic                                in_rev,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DWIDTH-1:0]            out_data,
  output logic                                out_last,
  output logic                                busy
);

  localparam int IW = (CORE > 1) ? $clog2(CORE) : 1;

  logic [CORE-1:0][DWIDTH-1:0] r_act_dat;
  logic [CWIDTH-1:0]           r_act_rem;
  logic                        r_act_vld;

  logic [CORE-1:0][DWIDTH-1:0] r_pnd_dat;
  logic [CWIDTH-1:0]           r_pnd_len;
  logic                        r_pnd_vld;

  logic [CWIDTH-1:0]           w_len;
  logic [CORE-1:0][DWIDTH-1:0] w_cap_dat;
  logic [CORE-1:0][DWIDTH-1:0] w_shift;
  logic                        w_acc;
  logic                        w_take;
  logic                        w_eov;

  // Out-of-range lengths (0 or above CORE) mean a full vector.
  assign w_len = ((in_len == '0) || (in_len > CWIDTH'(CORE))) ? CWIDTH'(CORE) : in_len;

  // Reverse at capture so the emit path is always a plain shift from element 0.
  always_comb begin
    w_cap_dat = '0;
    for (int k = 0; k < CORE; k++) begin
      if (!in_rev) begin
        w_cap_dat[IW'(k)] = in_data[IW'(k)];
      end else if (k < int'(w_len)) begin
        w_cap_dat[IW'(k)] = in_data[IW'(int'(w_len) - 1 - k)];
      end
    end
  end

  assign w_shift = r_act_dat >> DWIDTH;

  assign w_acc  = in_valid && !r_pnd_vld;
  assign w_take = r_act_vld && out_ready;
  assign w_eov  = w_take && (r_act_rem == CWIDTH'(1));

  always_ff @(posedge clk) begin
    if (!xrst || flush) begin
      r_act_dat <= '0;
      r_act_rem <= '0;
      r_act_vld <= 1'b0;
      r_pnd_dat <= '0;
      r_pnd_len <= '0;
      r_pnd_vld <= 1'b0;
    end else if (w_eov) begin
      if (r_pnd_vld) begin
        r_act_dat <= r_pnd_dat;
        r_act_rem <= r_pnd_len;
        r_act_vld <= 1'b1;
        r_pnd_dat <= '0;
        r_pnd_len <= '0;
        r_pnd_vld <= 1'b0;
      end else if (w_acc) begin
        r_act_dat <= w_cap_dat;
        r_act_rem <= w_len;
        r_act_vld <= 1'b1;
      end else begin
        r_act_dat <= '0;
        r_act_rem <= '0;
        r_act_vld <= 1'b0;
      end
    end else begin
      if (w_take) begin
        r_act_dat <= w_shift;
        r_act_rem <= r_act_rem - CWIDTH'(1);
      end
      if (w_acc) begin
        if (!r_act_vld) begin
          r_act_dat <= w_cap_dat;
          r_act_rem <= w_len;
          r_act_vld <= 1'b1;
        end else begin
          r_pnd_dat <= w_cap_dat;
          r_pnd_len <= w_len;
          r_pnd_vld <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = !r_pnd_vld;
  assign out_valid = r_act_vld;
  assign out_data  = r_act_vld ? $signed(r_act_dat[0]) : '0;
  assign out_last  = r_act_vld && (r_act_rem == CWIDTH'(1));
  assign busy      = r_act_vld || r_pnd_vld;

  // Pending is only ever filled behind a live active vector, and a live vector always has beats left.
  always_ff @(posedge clk) begin
    if (xrst && !flush) begin
      assert (!(r_pnd_vld && !r_act_vld));
      assert (!(r_act_vld && (r_act_rem == '0)));
    end
  end

endmodule

// File: tb/tb_serial_vec_stream.sv
// Directed bench for serial_vec_stream: reset, ordering, streaming, backpressure, length edges, mid-vector clear.
module tb_serial_vec_stream;

  logic                        clk = 1'b0;
  logic                        xrst;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [15:0][15:0]           in_data;
  logic [4:0]                  in_len;
  logic                        in_rev;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [15:0]          out_data;
  logic                        out_last;
  logic                        busy;

  int n_vec = 0;
  int n_err = 0;

  serial_vec_stream #(.DWIDTH(16), .CORE(16)) dut (
    .clk(clk), .xrst(xrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_len(in_len), .in_rev(in_rev),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0][15:0] seq(input int base);
    logic [15:0][15:0] v;
    for (int k = 0; k < 16; k++) v[k] = 16'(base + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    xrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_len = '0; in_rev = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    n_vec++;
    if ({out_valid, out_data, out_last, in_ready, busy} !== {1'b0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got valid=%b data=%0d last=%b in_ready=%b busy=%b, want 0 0 0 1 0",
               out_valid, out_data, out_last, in_ready, busy);
    end
    xrst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_data = seq(1); in_len = 5'd16; in_rev = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL basic in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_len = 5'd3;
    for (int i = 1; i <= 16; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'(i) || out_last !== (i == 16)) begin
        n_err++;
        $display("FAIL basic beat %0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_data, out_last, i, (i == 16));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic idle: got valid=%b data=%0d busy=%b, want 0 0 0", out_valid, out_data, busy);
    end
  endtask

  task automatic test_reverse();
    int exp [4] = '{13, 12, 11, 10};
    in_valid = 1'b1; in_data = seq(10); in_len = 5'd4; in_rev = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_rev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp[i]) || out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL reverse beat %0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_data, out_last, exp[i], (i == 3));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reverse extra beat: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0][15:0] vecs [3];
    int exp [9] = '{100, 101, 102, 200, 201, 202, 300, 301, 302};
    int idx = 0;
    bit acc;
    vecs[0] = seq(100); vecs[1] = seq(200); vecs[2] = seq(300);
    in_valid = 1'b1; in_data = vecs[0]; in_len = 5'd3; in_rev = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = in_valid && in_ready;
      if (c >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'(exp[c-1]) || out_last !== (c % 3 == 0)) begin
          n_err++;
          $display("FAIL b2b beat %0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                   c, out_valid, out_data, out_last, exp[c-1], (c % 3 == 0));
        end
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_data = vecs[idx];
        else in_valid = 1'b0;
      end
    end
    n_vec++;
    if (idx !== 3 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b accepts: got %0d accepted valid=%b, want 3 0", idx, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int exp_tail [5] = '{3, 40, 41, 50, 51};
    int last_tail [5] = '{1, 0, 1, 0, 1};
    in_valid = 1'b1; in_data = seq(1); in_len = 5'd3; in_rev = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = seq(40); in_len = 5'd2;
    n_vec++;
    if (out_data !== 16'sd2 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp second offer: got data=%0d in_ready=%b, want 2 1", out_data, in_ready);
    end
    tick();
    in_data = seq(50);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (in_ready !== 1'b0 || out_data !== 16'sd2 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp hold %0d: got in_ready=%b data=%0d valid=%b, want 0 2 1", i, in_ready, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp_tail[i]) || out_last !== last_tail[i][0]) begin
        n_err++;
        $display("FAIL bp order %0d: got valid=%b data=%0d last=%b, want 1 %0d %0d",
                 i, out_valid, out_data, out_last, exp_tail[i], last_tail[i]);
      end
      if (i == 0) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL bp ready on last: got %b want 0", in_ready);
        end
      end
      if (i == 1) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL bp third accept: got in_ready=%b want 1", in_ready);
        end
      end
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp drain: got valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_len_edges();
    logic [4:0] lens [3] = '{5'd0, 5'd20, 5'd1};
    bit         revs [3] = '{1'b0, 1'b1, 1'b0};
    int         want [3] = '{16, 16, 1};
    int beats;
    int e;
    bit bad;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; in_data = (t == 2) ? seq(77) : seq(1);
      in_len = lens[t]; in_rev = revs[t]; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      beats = 0; bad = 1'b0;
      for (int c = 0; c < 40 && out_valid; c++) begin
        if (t == 0) e = beats + 1;
        else if (t == 1) e = 16 - beats;
        else e = 77;
        beats++;
        if (out_data !== 16'(e) || out_last !== (beats == want[t])) bad = 1'b1;
        tick();
      end
      n_vec++;
      if (beats != want[t] || bad) begin
        n_err++;
        $display("FAIL len %0d rev %0d: got %0d beats data_ok=%b, want %0d beats data_ok=1",
                 lens[t], revs[t], beats, !bad, want[t]);
      end
    end
    in_rev = 1'b0;
  endtask

  task automatic test_mid(input bit use_flush);
    in_valid = 1'b1; in_data = seq(1); in_len = 5'd16; in_rev = 1'b0; out_ready = 1'b1;
    tick();
    in_data = seq(500);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    n_vec++;
    if (out_data !== 16'sd5 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid%0d pre: got data=%0d busy=%b in_ready=%b, want 5 1 0", use_flush, out_data, busy, in_ready);
    end
    if (use_flush) flush = 1'b1; else xrst = 1'b0;
    tick();
    flush = 1'b0; xrst = 1'b1;
    n_vec++;
    if ({out_valid, out_data, busy, in_ready} !== {1'b0, 16'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mid%0d cleared: got valid=%b data=%0d busy=%b in_ready=%b, want 0 0 0 1",
               use_flush, out_valid, out_data, busy, in_ready);
    end
    in_valid = 1'b1; in_data = seq(600); in_len = 5'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'(600 + i) || out_last !== (i == 1)) begin
        n_err++;
        $display("FAIL mid%0d restart beat %0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                 use_flush, i, out_valid, out_data, out_last, 600 + i, (i == 1));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid%0d restart tail: got valid=%b want 0", use_flush, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_back_to_back();
    test_backpressure();
    test_len_edges();
    test_mid(1'b0);
    test_mid(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
